// File: rtl/game_aux_units_if.sv
// -----------------------------------------------------------------------------
// game_aux_units_if
// Bundles the rectangle coordinates consumed by game_aux_units together with
// the three result signals it produces (strobe, random number, collision).
//
// Modports
//   master : the game logic side; drives the rectangle bounds and reads results
//   slave  : the aux-unit side; reads the rectangle bounds and drives results
//
// Signals
//   rect1_left/right, rect2_left/right  X_POS_W    horizontal bounds (right exclusive)
//   rect1_top/bottom, rect2_top/bottom  Y_POS_W    vertical bounds (bottom exclusive)
//   strobe_o                            1          one-cycle pulse every PERIOD clocks
//   rnd_num_o                           RND_NUM_W  pseudo-random number
//   collision_o                         1          registered rect1/rect2 overlap flag
// -----------------------------------------------------------------------------
interface game_aux_units_if #(
   parameter int X_POS_W   = 10,
   parameter int Y_POS_W   = 10,
   parameter int RND_NUM_W = 16
);
   logic [X_POS_W-1:0]   rect1_left;
   logic [X_POS_W-1:0]   rect1_right;
   logic [Y_POS_W-1:0]   rect1_top;
   logic [Y_POS_W-1:0]   rect1_bottom;
   logic [X_POS_W-1:0]   rect2_left;
   logic [X_POS_W-1:0]   rect2_right;
   logic [Y_POS_W-1:0]   rect2_top;
   logic [Y_POS_W-1:0]   rect2_bottom;
   logic                 strobe_o;
   logic [RND_NUM_W-1:0] rnd_num_o;
   logic                 collision_o;

   modport master (
      output rect1_left, rect1_right, rect1_top, rect1_bottom,
      output rect2_left, rect2_right, rect2_top, rect2_bottom,
      input  strobe_o, rnd_num_o, collision_o
   );

   modport slave (
      input  rect1_left, rect1_right, rect1_top, rect1_bottom,
      input  rect2_left, rect2_right, rect2_top, rect2_bottom,
      output strobe_o, rnd_num_o, collision_o
   );
endinterface

// File: rtl/game_aux_units.sv
// -----------------------------------------------------------------------------
// game_aux_units
// Three independent helper units for a small game engine, sharing only the
// clock and reset:
//   * strobe    : one-cycle pulse every PERIOD = CLK_FREQ_HZ/STROBE_FREQ_HZ clocks
//   * random    : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), low RND_NUM_W bits out
//   * collision : registered axis-aligned overlap test of two rectangles
//
// Ports
//   clk_i  input   system clock, all state on rising edge
//   rst_i  input   asynchronous active-high reset
//   bus    slave   game_aux_units_if (rectangle bounds in, strobe/rnd/collision out)
// -----------------------------------------------------------------------------
module game_aux_units #(
   parameter int CLK_FREQ_HZ    = 25_000_000,
   parameter int STROBE_FREQ_HZ = 100,
   parameter int X_POS_W        = 10,
   parameter int Y_POS_W        = 10,
   parameter int RND_NUM_W      = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   game_aux_units_if.slave    bus
);

   localparam int PERIOD = CLK_FREQ_HZ / STROBE_FREQ_HZ;
   localparam int CNT_W  = (PERIOD >= 2) ? $clog2(PERIOD) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [15:0]      LFSR_SEED = 16'hACE1;

   // Reject parameter sets that cannot produce a meaningful strobe or output.
   if (PERIOD < 2) begin : g_bad_period
      $error("game_aux_units: PERIOD = CLK_FREQ_HZ / STROBE_FREQ_HZ must be >= 2");
   end
   if (RND_NUM_W < 1 || RND_NUM_W > 16) begin : g_bad_rnd_w
      $error("game_aux_units: RND_NUM_W must be in 1..16");
   end

   logic [CNT_W-1:0] cnt;
   logic             strobe_q;
   logic [15:0]      lfsr;
   logic             lfsr_fb;
   logic             overlap;
   logic             collision_q;

   // Strobe divider: the pulse is registered on the edge where cnt wraps, so
   // the first pulse appears after the PERIOD-th edge following reset release.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt      <= '0;
         strobe_q <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt      <= '0;
         strobe_q <= 1'b1;
      end else begin
         cnt      <= cnt + CNT_ONE;
         strobe_q <= 1'b0;
      end
   end

   // Taps 15,13,12,10 give the maximal-length polynomial; a nonzero seed can
   // never reach the all-zero lock-up state.
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   // Strict comparisons make edge-touching rectangles non-colliding; the
   // explicit size checks keep a degenerate (zero width or height) rectangle
   // from ever colliding, even when it lies strictly inside the other one.
   assign overlap = (bus.rect1_left   <  bus.rect2_right)  &&
                    (bus.rect1_right  >  bus.rect2_left)   &&
                    (bus.rect1_top    <  bus.rect2_bottom) &&
                    (bus.rect1_bottom >  bus.rect2_top)    &&
                    (bus.rect1_left   != bus.rect1_right)  &&
                    (bus.rect1_top    != bus.rect1_bottom) &&
                    (bus.rect2_left   != bus.rect2_right)  &&
                    (bus.rect2_top    != bus.rect2_bottom);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         collision_q <= 1'b0;
      end else begin
         collision_q <= overlap;
      end
   end

   assign bus.strobe_o    = strobe_q;
   assign bus.rnd_num_o   = lfsr[RND_NUM_W-1:0];
   assign bus.collision_o = collision_q;

endmodule

// File: tb/tb_game_aux_units.sv
// -----------------------------------------------------------------------------
// tb_game_aux_units
// Self-checking bench for game_aux_units with PERIOD = 10/2 = 5.
// A reference model (edge counter, polynomial LFSR step, rectangle overlap
// rule) tracks the expected outputs after every clock edge; a table of
// rectangle pairs, random rectangles, a mid-operation reset and a full LFSR
// period exercise the design.
// -----------------------------------------------------------------------------
module tb_game_aux_units;

   localparam int XW     = 10;
   localparam int YW     = 10;
   localparam int RW     = 16;
   localparam int PERIOD = 5;
   localparam int NVEC   = 11;

   typedef struct {
      logic [XW-1:0] l1, r1;
      logic [YW-1:0] t1, b1;
      logic [XW-1:0] l2, r2;
      logic [YW-1:0] t2, b2;
      logic          exp;
   } vec_t;

   logic clk;
   logic rst;

   int          vectors;
   int          miscompares;
   int          edges;
   logic [15:0] lfsr_m;
   logic        col_m;
   vec_t        table_v [NVEC];

   game_aux_units_if #(.X_POS_W(XW), .Y_POS_W(YW), .RND_NUM_W(RW)) bus ();

   game_aux_units #(
      .CLK_FREQ_HZ   (10),
      .STROBE_FREQ_HZ(2),
      .X_POS_W       (XW),
      .Y_POS_W       (YW),
      .RND_NUM_W     (RW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rectangles (left,right,top,bottom); zero-size or touching never collides.
   function automatic logic model_overlap(int l1, int r1, int t1, int b1,
                                          int l2, int r2, int t2, int b2);
      if (l1 == r1 || t1 == b1 || l2 == r2 || t2 == b2) return 1'b0;
      return (l1 < r2) && (r1 > l2) && (t1 < b2) && (b1 > t2);
   endfunction

   // Polynomial x^16+x^14+x^13+x^11+1: feedback is the parity of the tapped bits.
   function automatic logic [15:0] next_lfsr(logic [15:0] s);
      logic fb;
      fb = ^(s & 16'hB400);
      return {s[14:0], fb};
   endfunction

   function automatic vec_t mk(int l1, int r1, int t1, int b1,
                               int l2, int r2, int t2, int b2, bit e);
      vec_t v;
      v.l1 = XW'(l1); v.r1 = XW'(r1); v.t1 = YW'(t1); v.b1 = YW'(b1);
      v.l2 = XW'(l2); v.r2 = XW'(r2); v.t2 = YW'(t2); v.b2 = YW'(b2);
      v.exp = e;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.rect1_left   = v.l1;
      bus.rect1_right  = v.r1;
      bus.rect1_top    = v.t1;
      bus.rect1_bottom = v.b1;
      bus.rect2_left   = v.l2;
      bus.rect2_right  = v.r2;
      bus.rect2_top    = v.t2;
      bus.rect2_bottom = v.b2;
   endtask

   // One rising edge: advance the model from the inputs seen at the edge,
   // then compare every output 1 time unit later.
   task automatic step();
      @(posedge clk);
      edges++;
      lfsr_m = next_lfsr(lfsr_m);
      col_m  = model_overlap(int'(bus.rect1_left), int'(bus.rect1_right),
                             int'(bus.rect1_top),  int'(bus.rect1_bottom),
                             int'(bus.rect2_left), int'(bus.rect2_right),
                             int'(bus.rect2_top),  int'(bus.rect2_bottom));
      #1;
      checkOutput("strobe",    32'(bus.strobe_o),    32'((edges % PERIOD) == 0));
      checkOutput("rnd",       32'(bus.rnd_num_o),   32'(lfsr_m));
      checkOutput("collision", 32'(bus.collision_o), 32'(col_m));
   endtask

   // Assert reset between edges, check outputs without a clock edge, then
   // release it away from the rising edge.
   task automatic applyReset();
      rst = 1'b1;
      #2;
      checkOutput("rst_strobe",    32'(bus.strobe_o),    32'd0);
      checkOutput("rst_rnd",       32'(bus.rnd_num_o),   32'hACE1);
      checkOutput("rst_collision", 32'(bus.collision_o), 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      edges  = 0;
      lfsr_m = 16'hACE1;
      col_m  = 1'b0;
   endtask

   task automatic randRect(output logic [XW-1:0] lo, output logic [XW-1:0] hi);
      int a, b;
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 63));
      lo = XW'((a < b) ? a : b);
      hi = XW'((a < b) ? b : a);
   endtask

   initial begin
      vec_t rv;
      logic [XW-1:0] lo, hi;

      vectors     = 0;
      miscompares = 0;
      edges       = 0;
      lfsr_m      = 16'hACE1;
      col_m       = 1'b0;
      rst         = 1'b1;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0));

      table_v[0]  = mk(20, 24, 100, 140,   22,  26, 120, 124, 1'b1);
      table_v[1]  = mk(20, 24, 100, 140,   24,  28, 120, 124, 1'b0);
      table_v[2]  = mk(20, 24, 100, 140,   10,  30, 140, 150, 1'b0);
      table_v[3]  = mk(20, 24, 100, 140,   10,  30,  90, 100, 1'b0);
      table_v[4]  = mk(20, 24, 100, 140,    0,  20, 110, 120, 1'b0);
      table_v[5]  = mk(20, 24, 100, 140,    0, 100,   0, 500, 1'b1);
      table_v[6]  = mk(50, 50,  10,  20,    0, 100,   0, 100, 1'b0);
      table_v[7]  = mk(20, 24, 100, 140,   21,  23, 110, 110, 1'b0);
      table_v[8]  = mk(20, 24, 100, 140,  500, 600, 500, 600, 1'b0);
      table_v[9]  = mk(20, 24, 100, 140,   20,  24, 100, 140, 1'b1);
      table_v[10] = mk(1000, 1023, 1000, 1023, 1022, 1023, 0, 1023, 1'b1);

      #12;
      applyReset();

      // First edge after release: LFSR advances to its documented successor.
      step();
      checkOutput("rnd_first_edge", 32'(bus.rnd_num_o), 32'h59C3);

      // Strobe pulses after edges 5, 10, 15 (checked inside step()).
      for (int i = 0; i < 15; i++) step();

      // Table of rectangle pairs, one-cycle collision latency.
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(table_v[i]);
         #1;
         if (i == 0) checkOutput("collision_before_edge", 32'(bus.collision_o), 32'd0);
         step();
         checkOutput($sformatf("table_%0d", i), 32'(bus.collision_o), 32'(table_v[i].exp));
      end

      // Random rectangles against the model.
      for (int i = 0; i < 300; i++) begin
         randRect(lo, hi); rv.l1 = lo; rv.r1 = hi;
         randRect(lo, hi); rv.t1 = lo; rv.b1 = hi;
         randRect(lo, hi); rv.l2 = lo; rv.r2 = hi;
         randRect(lo, hi); rv.t2 = lo; rv.b2 = hi;
         rv.exp = 1'b0;
         applyStimulus(rv);
         step();
      end

      // Mid-operation reset with collision high and cnt == 3.
      applyReset();
      applyStimulus(table_v[0]);
      for (int i = 0; i < 3; i++) step();
      checkOutput("collision_before_async_rst", 32'(bus.collision_o), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_collision", 32'(bus.collision_o), 32'd0);
      checkOutput("async_rst_strobe",    32'(bus.strobe_o),    32'd0);
      checkOutput("async_rst_rnd",       32'(bus.rnd_num_o),   32'hACE1);
      @(negedge clk);
      rst    = 1'b0;
      edges  = 0;
      lfsr_m = 16'hACE1;
      col_m  = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checkOutput("strobe_low_edge4", 32'(bus.strobe_o), 32'd0);
      step();
      checkOutput("strobe_high_edge5", 32'(bus.strobe_o), 32'd1);

      // Full LFSR period from the seed: never zero, back to the seed at the end.
      applyReset();
      for (int i = 0; i < 65535; i++) begin
         step();
         if (i < 65534) checkOutput("rnd_nonzero", 32'(bus.rnd_num_o != '0), 32'd1);
      end
      checkOutput("rnd_period_wrap", 32'(bus.rnd_num_o), 32'hACE1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
